io_port_unit: RTL and testbench

- Consumer end of the WB-stage I/O controls. Turns the OUT load strobe into a buffered valid/ack transfer to an external device.
- Captures strobed external input into a readable IN register that the WB path forces onto the RF write data for IN.
- Sits beside the register file in WB.
- Raises a stall toward the hazard unit when the output buffer cannot accept a store.

---
 rtl/io_pkg.sv | 15 +
 rtl/io_out_fifo.sv | 69 ++++++
 rtl/io_port_unit.sv | 98 +++++++++
 tb/tb_io_port_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the WB-stage I/O port: data width, I/O opcode and
// register-address selectors used by the decode and WB paths.
package io_pkg;

    localparam int IO_DATA_W = 8;
    localparam logic [3:0] OPC_IO = 4'd7;

    typedef enum logic [1:0] {
        RA_PUSH = 2'b00,
        RA_POP  = 2'b01,
        RA_OUT  = 2'b10,
        RA_IN   = 2'b11
    } io_ra_e;

endpackage

// File: rtl/io_out_fifo.sv
// Output buffer for OUT stores: power-of-two FIFO with a combinational head and
// a stall flag raised when a store arrives while full and nothing drains.
module io_out_fifo
    import io_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_req,
    input  logic [DATA_W-1:0] push_data,
    input  logic              ack,
    output logic [DATA_W-1:0] head_data,
    output logic              valid,
    output logic              stall
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ONE_PTR = ADDR_W'(1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              full_s;
    logic              pop_s;
    logic              push_s;

    // Handshake decode: a pop frees the slot a same-cycle push needs when full
    always_comb begin
        full_s = (count_r == FULL_CNT);
        pop_s  = (count_r != ZERO_CNT) && ack;
        push_s = push_req && (!full_s || pop_s);
        stall  = push_req && full_s && !pop_s;
        valid  = (count_r != ZERO_CNT);
        head_data = mem_r[rd_ptr_r];
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= ZERO_CNT;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_CNT;
                2'b01:   count_r <= count_r - ONE_CNT;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/io_port_unit.sv
// WB-stage I/O port: buffered OUT transfers and synchronized IN capture.
// Optional overwrite counter enabled by defining IO_OVERFLOW_CNT_EN.
module io_port_unit
    import io_pkg::*;
#(
    parameter int DATA_W    = IO_DATA_W,
    parameter int OUT_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_out,
    input  logic [DATA_W-1:0] out_wdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ack,
    output logic              io_stall,
    input  logic [DATA_W-1:0] in_pin,
    input  logic              in_strobe,
    input  logic              in_rd,
    output logic [DATA_W-1:0] in_rdata,
    output logic              in_avail,
    output logic [7:0]        in_ovf_cnt
);

    logic              sync1_r;
    logic              sync2_r;
    logic              edge_r;
    logic              rise_s;
    logic [DATA_W-1:0] in_rdata_r;
    logic              in_avail_r;

    io_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_req  (ld_out),
        .push_data (out_wdata),
        .ack       (out_ack),
        .head_data (out_data),
        .valid     (out_valid),
        .stall     (io_stall)
    );

    // Strobe is asynchronous: two flops for metastability, a third for edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            edge_r  <= 1'b0;
        end else begin
            sync1_r <= in_strobe;
            sync2_r <= sync1_r;
            edge_r  <= sync2_r;
        end
    end

    assign rise_s = sync2_r & ~edge_r;

    // Capture register; a fresh capture outranks a same-cycle read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_rdata_r <= {DATA_W{1'b0}};
            in_avail_r <= 1'b0;
        end else if (rise_s) begin
            in_rdata_r <= in_pin;
            in_avail_r <= 1'b1;
        end else if (in_rd) begin
            in_avail_r <= 1'b0;
        end else begin
            in_avail_r <= in_avail_r;
        end
    end

    assign in_rdata = in_rdata_r;
    assign in_avail = in_avail_r;

`ifdef IO_OVERFLOW_CNT_EN
    logic [7:0] ovf_cnt_r;

    // Count unread captures that get overwritten, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_r <= 8'h00;
        end else if (rise_s && in_avail_r && !in_rd && (ovf_cnt_r != 8'hFF)) begin
            ovf_cnt_r <= ovf_cnt_r + 8'h01;
        end else begin
            ovf_cnt_r <= ovf_cnt_r;
        end
    end

    assign in_ovf_cnt = ovf_cnt_r;
`else
    assign in_ovf_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_io_port_unit.sv
// Scoreboard bench for io_port_unit: driver predicts stall and queues accepted
// stores; a monitor checks outputs against the queue and an input-capture model.
module tb_io_port_unit;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_out = 1'b0;
    logic [7:0] out_wdata = 8'h00;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ack = 1'b0;
    logic       io_stall;
    logic [7:0] in_pin = 8'h00;
    logic       in_strobe = 1'b0;
    logic       in_rd = 1'b0;
    logic [7:0] in_rdata;
    logic       in_avail;
    logic [7:0] in_ovf_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    bit         lv[$];
    logic [7:0] m_rdata;
    bit         m_avail;
    int         m_ovf;

    io_port_unit #(.DATA_W(8), .OUT_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_out     (ld_out),
        .out_wdata  (out_wdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .io_stall   (io_stall),
        .in_pin     (in_pin),
        .in_strobe  (in_strobe),
        .in_rd      (in_rd),
        .in_rdata   (in_rdata),
        .in_avail   (in_avail),
        .in_ovf_cnt (in_ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Input model: a low-to-high change of in_strobe between two sampling edges
    // updates the IN register two edges after the high sample.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lv = {1'b0, 1'b0, 1'b0};
            m_rdata = 8'h00;
            m_avail = 1'b0;
            m_ovf = 0;
        end else begin
            bit cap;
            lv.push_back(in_strobe);
            cap = lv[lv.size()-3] && !lv[lv.size()-4];
            void'(lv.pop_front());
            if (cap) begin
                if (m_avail && !in_rd && m_ovf < 255) m_ovf++;
                m_rdata = in_pin;
                m_avail = 1'b1;
            end else if (in_rd) begin
                m_avail = 1'b0;
            end
        end
    end

    // Monitor: checks the head against the scoreboard and the IN side against the model
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("out_valid_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    chk("out_data", 32'(out_data), 32'(exp_q[0]));
                    if (out_ack) void'(exp_q.pop_front());
                end
            end
            chk("in_rdata", 32'(in_rdata), 32'(m_rdata));
            chk("in_avail", 32'(in_avail), 32'(m_avail));
`ifdef IO_OVERFLOW_CNT_EN
            chk("in_ovf_cnt", 32'(in_ovf_cnt), 32'(m_ovf));
`else
            chk("in_ovf_cnt", 32'(in_ovf_cnt), 32'd0);
`endif
        end
    end

    // Driver: one cycle of stimulus, predicting stall from scoreboard occupancy
    task automatic step(input logic ld, input logic [7:0] wd, input logic ack,
                        input logic stb, input logic [7:0] pin, input logic rd);
        int  occ;
        bit  pop_e;
        bit  stall_e;
        @(negedge clk);
        ld_out = ld; out_wdata = wd; out_ack = ack;
        in_strobe = stb; in_pin = pin; in_rd = rd;
        #1;
        occ = exp_q.size();
        pop_e = (occ > 0) && ack;
        stall_e = ld && (occ == DEPTH) && !pop_e;
        chk("io_stall", 32'(io_stall), 32'(stall_e));
        chk("out_valid", 32'(out_valid), 32'(occ > 0));
        if (ld && !stall_e) exp_q.push_back(wd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        ld_out = 1'b1; out_wdata = 8'hAA; out_ack = 1'b0;
        in_strobe = 1'b0; in_rd = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_avail", 32'(in_avail), 32'd0);
        chk("rst_in_ovf_cnt", 32'(in_ovf_cnt), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ld_out = 1'b0;
    endtask

    initial begin
        logic [7:0] cur_pin;
        bit ph_high;
        int ph_cnt;

        do_reset();
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        // Ordered output
        step(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);

        // Full, stall and same-cycle push/pop
        step(1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);

        // Input capture then read
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h5C, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h5C, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h5C, 1'b0);
        chk("cap_5c_avail", 32'(in_avail), 32'd1);
        chk("cap_5c_data", 32'(in_rdata), 32'h5C);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h5C, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h5C, 1'b0);
        chk("rd_clears_avail", 32'(in_avail), 32'd0);

        // Pending capture, then a new edge landing with in_rd
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h7E, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h7E, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h7E, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h7E, 1'b0);
        chk("cap_rd_avail", 32'(in_avail), 32'd1);
        chk("cap_rd_data", 32'(in_rdata), 32'h7E);

        // Randomized mixed traffic
        cur_pin = 8'h00; ph_high = 1'b0; ph_cnt = 0;
        for (int i = 0; i < 500; i++) begin
            if (ph_cnt == 0) begin
                if (ph_high) begin
                    ph_high = 1'b0;
                    ph_cnt = $urandom_range(2, 4);
                end else begin
                    ph_high = 1'b1;
                    ph_cnt = $urandom_range(1, 3);
                    cur_pin = 8'($urandom);
                end
            end
            ph_cnt--;
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                 ph_high, cur_pin, 1'($urandom_range(0, 3) == 0));
        end

        // Reset with entries buffered
        step(1'b1, 8'hB1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hB2, 1'b0, 1'b0, 8'h00, 1'b0);
        do_reset();
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);

        // Overflow saturation
        for (int i = 0; i < 300; i++) begin
            cur_pin = 8'($urandom);
            step(1'b0, 8'h00, 1'b0, 1'b1, cur_pin, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b0, cur_pin, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b0, cur_pin, 1'b0);
        end
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0, cur_pin, 1'b0);
`ifdef IO_OVERFLOW_CNT_EN
        chk("ovf_saturated", 32'(in_ovf_cnt), 32'd255);
`else
        chk("ovf_tied_zero", 32'(in_ovf_cnt), 32'd0);
`endif
        chk("ovf_last_data", 32'(in_rdata), 32'(cur_pin));

        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, cur_pin, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
